// File: rtl/shift_result_stage_pkg.sv
// Shared types for the shift result stage: skid state encoding, flag bit
// positions and the per-entry record captured when a result is accepted.
// No logic lives here; latency and backpressure are defined by the users.
package shift_result_stage_pkg;

  localparam int DATA_W = 24;
  localparam int TAG_W  = 4;

  // Bit positions inside the {N,Z,C} flags vector
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skidState_t;

  // Everything writeback and the flag logic need, frozen at accept time
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [TAG_W-1:0]  rd;
    logic              setflags;
    logic              n;
    logic              z;
    logic              c;
    logic              cKeep;
  } entry_t;

endpackage

// File: rtl/shift_carry_calc.sv
// Shifter carry-out derived from the pre-shift operand, amount and direction.
// Purely combinational, zero latency.
// No handshake; the result is consumed in the same cycle it is presented.
module shift_carry_calc
  import shift_result_stage_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] operand,
  input  logic [4:0]       amt,
  input  logic             dir,
  output logic             carry,
  output logic             carryKeep
);

  logic [4:0] bitIdx;

  // Last bit shifted out: left takes operand[W-amt], arithmetic right takes
  // operand[amt-1]; beyond the width, left yields 0 and right yields the sign.
  always_comb begin
    carry     = 1'b0;
    carryKeep = 1'b0;
    bitIdx    = '0;
    if (amt == 5'd0) begin
      carryKeep = 1'b1;
    end else if (int'(amt) > WIDTH) begin
      carry = dir ? operand[WIDTH-1] : 1'b0;
    end else begin
      bitIdx = dir ? (amt - 5'd1) : (5'(WIDTH) - amt);
      carry  = operand[bitIdx];
    end
  end

endmodule

// File: rtl/shift_result_stage.sv
// Registers barrel-shifter results with their tag and commits N/Z/C flags.
// Latency: 1 cycle in-to-out; full throughput via a 2-entry skid buffer.
// Backpressure: in_ready is registered and drops only when both entries are held.
module shift_result_stage
  import shift_result_stage_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int RD_W  = TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [WIDTH-1:0] in_operand,
  input  logic [4:0]       in_amt,
  input  logic             in_dir,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             in_setflags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic [2:0]       flags
);

  skidState_t state, stateNext;
  entry_t     head, skid, newEntry;
  logic       inReadyQ;
  logic [2:0] flagsQ;
  logic       accept, commit;
  logic       loadHeadNew, loadSkidNew, moveSkid;
  logic       newCarry, newCarryKeep;

  shift_carry_calc #(.WIDTH(WIDTH)) u_carry (
    .operand   (in_operand),
    .amt       (in_amt),
    .dir       (in_dir),
    .carry     (newCarry),
    .carryKeep (newCarryKeep)
  );

  assign accept = in_valid && inReadyQ;
  assign commit = (state != ST_EMPTY) && out_ready;

  // Build the entry record for the incoming result
  always_comb begin
    newEntry          = '0;
    newEntry.result   = in_result;
    newEntry.rd       = in_rd;
    newEntry.setflags = in_setflags;
    newEntry.n        = in_result[WIDTH-1];
    newEntry.z        = (in_result == '0);
    newEntry.c        = newCarry;
    newEntry.cKeep    = newCarryKeep;
  end

  // Skid occupancy next-state and entry-move controls; flush overrides all moves
  always_comb begin
    stateNext   = state;
    loadHeadNew = 1'b0;
    loadSkidNew = 1'b0;
    moveSkid    = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          stateNext   = ST_ONE;
          loadHeadNew = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && commit) begin
          loadHeadNew = 1'b1;
        end else if (accept) begin
          stateNext   = ST_FULL;
          loadSkidNew = 1'b1;
        end else if (commit) begin
          stateNext = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (commit) begin
          stateNext = ST_ONE;
          moveSkid  = 1'b1;
        end
      end
      default: stateNext = ST_EMPTY;
    endcase
    if (flush) begin
      stateNext   = ST_EMPTY;
      loadHeadNew = 1'b0;
      loadSkidNew = 1'b0;
      moveSkid    = 1'b0;
    end
  end

  // State register; ready is precomputed from next state so it never sees out_ready combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      inReadyQ <= 1'b1;
    end else begin
      state    <= stateNext;
      inReadyQ <= (stateNext != ST_FULL);
    end
  end

  // Entry storage; head keeps its last contents when the stage drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (loadHeadNew) begin
        head <= newEntry;
      end else if (moveSkid) begin
        head <= skid;
      end
      if (loadSkidNew) begin
        skid <= newEntry;
      end
    end
  end

  // Architectural flags update on commit; a flushed commit still counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flagsQ <= 3'b000;
    end else if (commit && head.setflags) begin
      flagsQ[FLAG_N] <= head.n;
      flagsQ[FLAG_Z] <= head.z;
      flagsQ[FLAG_C] <= head.cKeep ? flagsQ[FLAG_C] : head.c;
    end
  end

  assign in_ready   = inReadyQ;
  assign out_valid  = (state != ST_EMPTY);
  assign out_result = head.result;
  assign out_rd     = head.rd;
  assign flags      = flagsQ;

endmodule

// File: tb/tb_shift_result_stage.sv
module tb_shift_result_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_result;
  logic [23:0] in_operand;
  logic [4:0]  in_amt;
  logic        in_dir;
  logic [3:0]  in_rd;
  logic        in_setflags;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_result;
  logic [3:0]  out_rd;
  logic [2:0]  flags;

  shift_result_stage #(.WIDTH(24), .RD_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_operand  (in_operand),
    .in_amt      (in_amt),
    .in_dir      (in_dir),
    .in_rd       (in_rd),
    .in_setflags (in_setflags),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .flags       (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] result;
    logic [23:0] operand;
    logic [4:0]  amt;
    logic        dir;
    logic [3:0]  rd;
    logic        sf;
  } ent_t;

  ent_t        q[$];
  logic [2:0]  mFlags;
  logic [23:0] holdResult;
  logic [3:0]  holdRd;
  logic        lastAccepted;
  int          checks;
  int          errors;
  int          dutCommits;
  int          readyLow;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shifter behaviour in plain arithmetic
  function automatic logic [23:0] shiftRef(input logic [23:0] op, input logic [4:0] amt, input logic dir);
    logic [63:0]        u;
    logic signed [63:0] s;
    u = 64'(op) << amt;
    s = {{40{op[23]}}, op};
    s = s >>> amt;
    return dir ? s[23:0] : u[23:0];
  endfunction

  // Flags after committing e: carry is the last bit pushed out of the operand
  function automatic logic [2:0] flagsAfter(input ent_t e, input logic [2:0] f);
    logic [63:0]        u;
    logic signed [63:0] s;
    logic               c;
    if (e.amt == 5'd0) begin
      c = f[0];
    end else if (!e.dir) begin
      u = 64'(e.operand) << e.amt;
      c = u[24];
    end else begin
      s = {{40{e.operand[23]}}, e.operand};
      s = s >>> (e.amt - 5'd1);
      c = s[0];
    end
    return {e.result[23], (e.result == 24'd0), c};
  endfunction

  task automatic drive(input logic [23:0] op, input logic [4:0] amt, input logic dir,
                       input logic [3:0] rd, input logic sf);
    in_valid    = 1'b1;
    in_operand  = op;
    in_amt      = amt;
    in_dir      = dir;
    in_rd       = rd;
    in_setflags = sf;
    in_result   = shiftRef(op, amt, dir);
  endtask

  task automatic driveRandom();
    drive(24'($urandom), 5'($urandom_range(0, 31)), 1'($urandom), 4'($urandom), 1'($urandom));
  endtask

  // One clock: check outputs against the model at the falling edge, advance
  // the model over the coming rising edge, return at rising edge + 1
  task automatic cycle();
    logic expValid, expReady, acc, com;
    ent_t e;
    @(negedge clk);
    expValid = (q.size() != 0);
    expReady = (q.size() < 2);
    check("out_valid", 32'(out_valid), 32'(expValid));
    check("in_ready", 32'(in_ready), 32'(expReady));
    check("flags", 32'(flags), 32'(mFlags));
    if (expValid) begin
      holdResult = q[0].result;
      holdRd     = q[0].rd;
    end
    check("out_result", 32'(out_result), 32'(holdResult));
    check("out_rd", 32'(out_rd), 32'(holdRd));
    if (out_valid && out_ready) dutCommits++;
    if (!in_ready) readyLow++;
    acc = in_valid && expReady;
    com = expValid && out_ready;
    if (com) begin
      e = q.pop_front();
      if (e.sf) mFlags = flagsAfter(e, mFlags);
    end
    if (flush) begin
      q.delete();
    end else if (acc) begin
      e.result  = in_result;
      e.operand = in_operand;
      e.amt     = in_amt;
      e.dir     = in_dir;
      e.rd      = in_rd;
      e.sf      = in_setflags;
      q.push_back(e);
    end
    lastAccepted = acc && !flush;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; dutCommits = 0; readyLow = 0;
    mFlags = 3'b000; holdResult = '0; holdRd = '0; lastAccepted = 1'b0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_result = '0; in_operand = '0;
    in_amt = '0; in_dir = 1'b0; in_rd = '0; in_setflags = 1'b0; out_ready = 1'b0;

    // Reset values
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_rd", 32'(out_rd), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Arithmetic right by 1 of a negative odd value
    out_ready = 1'b1;
    drive(24'h800001, 5'd1, 1'b1, 4'd3, 1'b1);
    check("t1_result_stim", 32'(in_result), 32'hC00000);
    cycle();
    in_valid = 1'b0;
    cycle();
    check("t1_flags", 32'(flags), 32'b101);

    // Left by the full width, then amt 0 keeps C
    drive(24'h000001, 5'd24, 1'b0, 4'd4, 1'b1);
    cycle();
    drive(24'h000005, 5'd0, 1'b0, 4'd5, 1'b1);
    cycle();
    check("t2_flags_amt24", 32'(flags), 32'b011);
    in_valid = 1'b0;
    cycle();
    check("t2_flags_amt0", 32'(flags), 32'b001);

    // Beyond-width shifts
    drive(24'h800000, 5'd31, 1'b1, 4'd6, 1'b1);
    cycle();
    in_valid = 1'b0;
    cycle();
    check("t3_flags_r31", 32'(flags), 32'b101);
    drive(24'h800000, 5'd31, 1'b0, 4'd7, 1'b1);
    cycle();
    in_valid = 1'b0;
    cycle();
    check("t3_flags_l31", 32'(flags), 32'b010);

    // Backpressure with three back-to-back inputs
    out_ready = 1'b0;
    drive(24'h000011, 5'd2, 1'b0, 4'd1, 1'b0);
    cycle();
    drive(24'h000022, 5'd3, 1'b0, 4'd2, 1'b0);
    cycle();
    check("t4_ready_full", 32'(in_ready), 32'd0);
    drive(24'h000033, 5'd4, 1'b0, 4'd3, 1'b0);
    cycle();
    check("t4_head_rd", 32'(out_rd), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (lastAccepted) in_valid = 1'b0;
    end
    check("t4_drained", 32'(out_valid), 32'd0);
    check("t4_last_rd", 32'(out_rd), 32'd3);

    // Flush while full, with a same-cycle input
    out_ready = 1'b0;
    drive(24'h000100, 5'd1, 1'b0, 4'd8, 1'b1);
    cycle();
    drive(24'h000000, 5'd1, 1'b0, 4'd9, 1'b1);
    cycle();
    flush = 1'b1;
    drive(24'h000200, 5'd1, 1'b1, 4'd10, 1'b1);
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_flags", 32'(flags), 32'b010);
    cycle();

    // Streaming at full rate
    out_ready = 1'b1;
    dutCommits = 0;
    readyLow = 0;
    for (int i = 0; i < 100; i++) begin
      driveRandom();
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("t6_commits", 32'(dutCommits), 32'd100);
    check("t6_ready_low", 32'(readyLow), 32'd0);

    // Random valid, ready and flush
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) driveRandom();
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 24) == 0);
      cycle();
    end
    flush = 1'b0;

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    driveRandom();
    cycle();
    cycle();
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_flags", 32'(flags), 32'd0);
    check("arst_out_result", 32'(out_result), 32'd0);
    q.delete();
    mFlags = 3'b000;
    holdResult = '0;
    holdRd = '0;
    in_valid = 1'b0;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      driveRandom();
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
